// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transceiver: default rates, bit-timer sizing,
// FSM encodings and bit positions within the 2-bit port state word.
package uart_pkg;

    localparam int CLK_HZ_DEFAULT = 11059200;
    localparam int BAUD_DEFAULT   = 115200;
    localparam int DIV            = CLK_HZ_DEFAULT / BAUD_DEFAULT;
    localparam int BIT_CNT_W      = $clog2(DIV);

    localparam int STATE_TX_READY = 0;
    localparam int STATE_RX_VALID = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_fsm_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive buffer, DEPTH x 8, show-ahead head that reads 0x00 when empty.
// A pop and a push in the same cycle on a full buffer both succeed.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART core for serial port 2: TX FSM, synchronised RX FSM and RX FIFO.
// Defining UART_PARITY_EN adds an even parity bit between data and stop in both directions.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int BAUD     = BAUD_DEFAULT,
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic [1:0] state,
    output logic       rx_overrun,
    output logic       frame_err,
    input  logic       rxd_pin,
    output logic       txd_pin
);

    localparam int BIT_DIV = CLK_HZ / BAUD;
    localparam int CW      = $clog2(BIT_DIV);
    localparam logic [CW-1:0] LAST      = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);

    // ---------------- transmit ----------------
    uart_fsm_e     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic          txd_n;
`ifdef UART_PARITY_EN
    logic          tx_par, tx_par_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            txd_pin  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            txd_pin  <= txd_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // txd_pin is registered, so each state's line level is set on the edge entering it.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_idx_n   = tx_idx;
        tx_sh_n    = tx_sh;
        txd_n      = txd_pin;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (wr_en) begin
                    tx_sh_n    = wr_data;
                    txd_n      = 1'b0;
                    tx_state_n = ST_START;
`ifdef UART_PARITY_EN
                    tx_par_n   = ^wr_data;
`endif
                end
            end
            ST_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    txd_n      = tx_sh[0];
                    tx_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n = '0;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        txd_n      = tx_par;
                        tx_state_n = ST_PARITY;
`else
                        txd_n      = 1'b1;
                        tx_state_n = ST_STOP;
`endif
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                        txd_n    = tx_sh[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    txd_n      = 1'b1;
                    tx_state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = ST_IDLE;
                end
            end
            default: begin
                tx_cnt_n   = '0;
                txd_n      = 1'b1;
                tx_state_n = ST_IDLE;
            end
        endcase
    end

    // ---------------- receive ----------------
    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          rx_prev;
    uart_fsm_e     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic          rx_push;
    logic          frame_err_n;
    logic          rx_good;
`ifdef UART_PARITY_EN
    logic          rx_par_ok, rx_par_ok_n;
`endif

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync   <= 2'b11;
            rx_prev   <= 1'b1;
            rx_state  <= ST_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_sh     <= '0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok <= 1'b0;
`endif
        end else begin
            rx_sync   <= {rx_sync[0], rxd_pin};
            rx_prev   <= rx_s;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_idx    <= rx_idx_n;
            rx_sh     <= rx_sh_n;
            frame_err <= frame_err_n;
`ifdef UART_PARITY_EN
            rx_par_ok <= rx_par_ok_n;
`endif
        end
    end

`ifdef UART_PARITY_EN
    assign rx_good = rx_s && rx_par_ok;
`else
    assign rx_good = rx_s;
`endif

    // Only a high-to-low transition arms START, so a line held low after a bad frame stays ignored.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + CW'(1);
        rx_idx_n    = rx_idx;
        rx_sh_n     = rx_sh;
        rx_push     = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_ok_n = rx_par_ok;
`endif
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s) rx_state_n = ST_START;
            end
            ST_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = ST_PARITY;
`else
                        rx_state_n = ST_STOP;
`endif
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n    = '0;
                    rx_par_ok_n = (rx_s == ^rx_sh);
                    rx_state_n  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n    = '0;
                    rx_state_n  = ST_IDLE;
                    rx_push     = rx_good;
                    frame_err_n = !rx_good;
                end
            end
            default: begin
                rx_cnt_n   = '0;
                rx_state_n = ST_IDLE;
            end
        endcase
    end

    // ---------------- FIFO and status ----------------
    logic fifo_full;
    logic fifo_empty;

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_sh),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A same-cycle read frees a slot, so a push into a full FIFO only overruns without rd_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       rx_overrun <= 1'b0;
        else if (rd_en)                 rx_overrun <= 1'b0;
        else if (rx_push && fifo_full)  rx_overrun <= 1'b1;
    end

    assign state[STATE_TX_READY] = (tx_state == ST_IDLE);
    assign state[STATE_RX_VALID] = !fifo_empty;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: TX waveform, RX frames, FIFO overrun, framing
// errors, start-bit glitch rejection and asynchronous reset; honours UART_PARITY_EN.
module tb_uart_transceiver;

    localparam int DIV = 96;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [1:0] state;
    logic       rx_overrun;
    logic       frame_err;
    logic       rxd_pin;
    logic       txd_pin;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    int         ferr_seen;
    int         rise_k;

    uart_transceiver dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .state      (state),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .rxd_pin    (rxd_pin),
        .txd_pin    (txd_pin)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Send one byte on TX and check the line level over every clock of every bit.
    task automatic tx_frame(input logic [7:0] data, input bit poke_busy);
        logic [NB-1:0] bits;
        int            low_cnt;
        int            bad;
`ifdef UART_PARITY_EN
        bits = {1'b1, ^data, data, 1'b0};
`else
        bits = {1'b1, data, 1'b0};
`endif
        @(negedge clk);
        wr_data = data;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'h00;
        low_cnt = 0;
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int i = 0; i < DIV; i++) begin
                if (txd_pin !== bits[b]) bad++;
                if (state[0] == 1'b0) low_cnt++;
                wr_en = (poke_busy && b == 3 && i == 10);
                @(negedge clk);
            end
            check($sformatf("tx_%02h_bit%0d", data, b), bad, 0);
        end
        wr_en = 1'b0;
        check("tx_ready_low_clks", low_cnt, NB * DIV);
        check("tx_ready_back", state[0], 1);
        repeat (3) @(negedge clk);
        check("tx_no_queue_txd", txd_pin, 1);
        check("tx_no_queue_ready", state[0], 1);
    endtask

    // Drive one RX frame at DIV clocks per bit, then a short idle; updates the reference model.
    task automatic send_rx(input logic [7:0] data, input logic stop_bit, input bit bad_par);
        logic [NB-1:0] bits;
`ifdef UART_PARITY_EN
        bits = {stop_bit, (^data) ^ bad_par, data, 1'b0};
`else
        bits = {stop_bit, data, 1'b0};
`endif
        ferr_seen = 0;
        rise_k    = -1;
        for (int b = 0; b < NB; b++) begin
            rxd_pin = bits[b];
            for (int i = 1; i <= DIV; i++) begin
                @(negedge clk);
                if (frame_err) ferr_seen++;
                if (b == NB - 1 && rise_k < 0 && state[1]) rise_k = i;
            end
        end
        rxd_pin = 1'b1;
        repeat (DIV / 4) begin
            @(negedge clk);
            if (frame_err) ferr_seen++;
        end
        if (stop_bit && !bad_par) begin
            if (exp_q.size() < 4) exp_q.push_back(data);
            else                  exp_ovr = 1'b1;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check(tag, rd_data, e);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        exp_ovr = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        rxd_pin = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", txd_pin, 1);
        check("rst_state", state, 2'b01);
        check("rst_overrun", rx_overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rd_data", rd_data, 8'h00);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // TX 0x55 with an ignored write mid-frame
        tx_frame(8'h55, 1'b1);

        // RX 0xA5 into an empty FIFO
        send_rx(8'hA5, 1'b1, 1'b0);
        check("rx_valid_latency_ok", (rise_k >= 48 && rise_k <= 51), 1);
        check("rx_a5_no_ferr", ferr_seen, 0);
        check("rx_a5_valid", state[1], 1);
        pop_check("rx_a5_data");
        check("rx_a5_drained", state[1], 0);

        // Overrun: five bytes into a four-entry FIFO
        for (int k = 1; k <= 5; k++) send_rx(8'(k), 1'b1, 1'b0);
        check("ovr_set", rx_overrun, exp_ovr);
        pop_check("ovr_rd1");
        check("ovr_cleared", rx_overrun, 0);
        pop_check("ovr_rd2");
        pop_check("ovr_rd3");
        pop_check("ovr_rd4");
        check("ovr_empty_valid", state[1], 0);
        check("ovr_empty_data", rd_data, 8'h00);

        // Bad stop bit then a good frame
        send_rx(8'hC3, 1'b0, 1'b0);
        check("ferr_pulse_cnt", ferr_seen, 1);
        check("ferr_no_push", state[1], 0);
        send_rx(8'h3C, 1'b1, 1'b0);
        check("ferr_next_ok", state[1], 1);
        pop_check("ferr_next_data");

        // Start-bit glitch
        ferr_seen = 0;
        rxd_pin   = 1'b0;
        repeat (20) @(negedge clk);
        rxd_pin = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (frame_err) ferr_seen++;
        end
        check("glitch_no_ferr", ferr_seen, 0);
        check("glitch_no_push", state[1], 0);
        send_rx(8'h81, 1'b1, 1'b0);
        check("glitch_next_ok", state[1], 1);
        pop_check("glitch_next_data");

`ifdef UART_PARITY_EN
        send_rx(8'h07, 1'b1, 1'b1);
        check("par_bad_ferr", ferr_seen, 1);
        check("par_bad_no_push", state[1], 0);
`endif

        // Asynchronous reset during the start bit of a 0xFF transmit, with a byte buffered
        send_rx(8'h5A, 1'b1, 1'b0);
        check("rst_pre_valid", state[1], 1);
        @(negedge clk);
        wr_data = 8'hFF;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_pre_txd", txd_pin, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_txd", txd_pin, 1);
        check("arst_state", state, 2'b01);
        check("arst_rd_data", rd_data, 8'h00);
        exp_q.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", state, 2'b01);
        check("post_rst_txd", txd_pin, 1);
        check("post_rst_overrun", rx_overrun, 0);

        // TX 0x07 (odd weight: parity bit 1 when enabled)
        tx_frame(8'h07, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
